// File: rtl/conv_pkg.sv
// Shared widths and the wrap/saturate adder for the convolution MAC datapath.
package conv_pkg;

  localparam int INW_DEF  = 8;
  localparam int OUTW_DEF = 24;
  // Working width of sat_add; OUTW must leave two bits of headroom so a+b cannot overflow.
  localparam int MAXW     = 64;

  // a and b are sign-extended OUTW-bit values; the result is the OUTW-bit sum, sign-extended to MAXW.
  function automatic logic signed [MAXW-1:0] sat_add(
    input logic signed [MAXW-1:0] a,
    input logic signed [MAXW-1:0] b,
    input logic                   sat,
    input int                     outw
  );
    logic signed [MAXW-1:0] one;
    logic signed [MAXW-1:0] sum;
    logic signed [MAXW-1:0] hi;
    logic signed [MAXW-1:0] lo;
    logic signed [MAXW-1:0] res;
    one = {{(MAXW-1){1'b0}}, 1'b1};
    sum = a + b;
    hi  = (one <<< (outw - 1)) - one;
    lo  = ~hi;
    if (sat) begin
      if (sum > hi) begin
        res = hi;
      end else if (sum < lo) begin
        res = lo;
      end else begin
        res = sum;
      end
    end else begin
      res = (sum <<< (MAXW - outw)) >>> (MAXW - outw);
    end
    return res;
  endfunction

endpackage

// File: rtl/conv_mac_stage_mac_accum.sv
// Stage-2 window accumulator: adds the registered product into acc, wrapping or saturating.
module mac_accum
  import conv_pkg::*;
#(
  parameter int INW  = INW_DEF,
  parameter int OUTW = OUTW_DEF,
  parameter int SAT  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en_acc,
  input  logic              s1_last,
  input  logic [2*INW-1:0]  s1_prod,
  output logic [OUTW-1:0]   acc_next
);

  logic [OUTW-1:0]        acc_q;
  logic [OUTW-1:0]        acc_d;
  logic signed [MAXW-1:0] sum_w;

  always_comb begin
    sum_w    = sat_add(MAXW'($signed(acc_q)), MAXW'($signed(s1_prod)), SAT != 0, OUTW);
    acc_next = sum_w[OUTW-1:0];
    acc_d    = acc_q;
    // A closing pair hands its sum to the output register and restarts the window at zero.
    if (en_acc) begin
      acc_d = s1_last ? '0 : acc_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/conv_mac_stage.sv
// Two-stage signed multiply-accumulate feeding the output FIFO, one result per operand window.
module conv_mac_stage
  import conv_pkg::*;
#(
  parameter int INW  = INW_DEF,
  parameter int OUTW = OUTW_DEF,
  parameter int SAT  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2*INW-1:0]  IN_AXIS_TDATA,
  input  logic              IN_AXIS_TVALID,
  input  logic              IN_AXIS_TLAST,
  output logic              IN_AXIS_TREADY,
  output logic [OUTW-1:0]   OUT_AXIS_TDATA,
  output logic              OUT_AXIS_TVALID,
  input  logic              OUT_AXIS_TREADY
);

  if (OUTW < 2*INW || OUTW > MAXW - 2) begin : g_bad_width
    $error("conv_mac_stage: OUTW must be >= 2*INW and <= %0d", MAXW - 2);
  end

  logic                   en;
  logic                   accepted;
  logic signed [INW-1:0]  x_w;
  logic signed [INW-1:0]  w_w;
  logic [2*INW-1:0]       prod_w;
  logic [OUTW-1:0]        acc_next;

  logic                   s1_v_q, s1_v_d;
  logic                   s1_last_q, s1_last_d;
  logic [2*INW-1:0]       s1_prod_q, s1_prod_d;
  logic                   out_valid_q, out_valid_d;
  logic [OUTW-1:0]        out_data_q, out_data_d;

  always_comb begin
    en             = !(out_valid_q && !OUT_AXIS_TREADY);
    // Output valid is forced low by reset one edge late, so ready is asserted explicitly here.
    IN_AXIS_TREADY = en || reset;
    accepted       = IN_AXIS_TVALID && IN_AXIS_TREADY;
    x_w            = IN_AXIS_TDATA[2*INW-1:INW];
    w_w            = IN_AXIS_TDATA[INW-1:0];
    prod_w         = (2*INW)'(x_w) * (2*INW)'(w_w);

    s1_v_d      = s1_v_q;
    s1_last_d   = s1_last_q;
    s1_prod_d   = s1_prod_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (en) begin
      s1_v_d      = accepted;
      s1_last_d   = IN_AXIS_TLAST;
      s1_prod_d   = prod_w;
      out_valid_d = s1_v_q && s1_last_q;
      if (s1_v_q && s1_last_q) begin
        out_data_d = acc_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_v_q      <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_prod_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      s1_v_q      <= s1_v_d;
      s1_last_q   <= s1_last_d;
      s1_prod_q   <= s1_prod_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  mac_accum #(
    .INW  (INW),
    .OUTW (OUTW),
    .SAT  (SAT)
  ) u_mac_accum (
    .clk      (clk),
    .reset    (reset),
    .en_acc   (en && s1_v_q),
    .s1_last  (s1_last_q),
    .s1_prod  (s1_prod_q),
    .acc_next (acc_next)
  );

  assign OUT_AXIS_TDATA  = out_data_q;
  assign OUT_AXIS_TVALID = out_valid_q;

endmodule

// File: tb/tb_conv_mac_stage.sv
// Bench for conv_mac_stage: three configurations share one stream and are checked against a window-sum model.
module tb_conv_mac_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_last;
  logic        out_ready;

  logic        rdy_a, rdy_b, rdy_c;
  logic        val_a, val_b, val_c;
  logic [23:0] data_a;
  logic [15:0] data_b;
  logic [15:0] data_c;

  always #5 clk = ~clk;

  conv_mac_stage #(.INW(8), .OUTW(24), .SAT(0)) dut_a (
    .clk(clk), .reset(reset),
    .IN_AXIS_TDATA(in_data), .IN_AXIS_TVALID(in_valid), .IN_AXIS_TLAST(in_last),
    .IN_AXIS_TREADY(rdy_a),
    .OUT_AXIS_TDATA(data_a), .OUT_AXIS_TVALID(val_a), .OUT_AXIS_TREADY(out_ready)
  );

  conv_mac_stage #(.INW(8), .OUTW(16), .SAT(1)) dut_b (
    .clk(clk), .reset(reset),
    .IN_AXIS_TDATA(in_data), .IN_AXIS_TVALID(in_valid), .IN_AXIS_TLAST(in_last),
    .IN_AXIS_TREADY(rdy_b),
    .OUT_AXIS_TDATA(data_b), .OUT_AXIS_TVALID(val_b), .OUT_AXIS_TREADY(out_ready)
  );

  conv_mac_stage #(.INW(8), .OUTW(16), .SAT(0)) dut_c (
    .clk(clk), .reset(reset),
    .IN_AXIS_TDATA(in_data), .IN_AXIS_TVALID(in_valid), .IN_AXIS_TLAST(in_last),
    .IN_AXIS_TREADY(rdy_c),
    .OUT_AXIS_TDATA(data_c), .OUT_AXIS_TVALID(val_c), .OUT_AXIS_TREADY(out_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Reference model: per-configuration running window sum and queue of pending results.
  longint q0[$];
  longint q1[$];
  longint q2[$];
  longint part[3];
  bit     hold[3];
  longint held[3];

  function automatic int cfg_outw(int k);
    return (k == 0) ? 24 : 16;
  endfunction

  function automatic bit cfg_sat(int k);
    return k == 1;
  endfunction

  function automatic longint step(longint acc, longint p, int outw, bit sat);
    longint s, lim, m;
    s   = acc + p;
    lim = longint'(1) << (outw - 1);
    m   = longint'(1) << outw;
    if (sat) begin
      if (s > lim - 1) s = lim - 1;
      else if (s < -lim) s = -lim;
    end else begin
      s = s % m;
      if (s >= lim) s -= m;
      else if (s < -lim) s += m;
    end
    return s;
  endfunction

  task automatic q_push(input int k, input longint v);
    case (k)
      0: q0.push_back(v);
      1: q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endtask

  task automatic q_pop(input int k, output longint v, output bit ok);
    ok = 1'b1;
    v  = 0;
    case (k)
      0: if (q0.size() > 0) v = q0.pop_front(); else ok = 1'b0;
      1: if (q1.size() > 0) v = q1.pop_front(); else ok = 1'b0;
      default: if (q2.size() > 0) v = q2.pop_front(); else ok = 1'b0;
    endcase
  endtask

  task automatic port_check(input int k, input logic v, input longint d, input logic r);
    longint e;
    bit     ok;
    longint prod;
    chk($sformatf("in_ready%0d", k), longint'(r), longint'(!(v && !out_ready)));
    if (hold[k]) begin
      chk($sformatf("hold_valid%0d", k), longint'(v), 1);
      chk($sformatf("hold_data%0d", k), d, held[k]);
    end
    if (v && out_ready) begin
      q_pop(k, e, ok);
      if (!ok) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result%0d: got %0d, expected no result pending at %0t", k, d, $time);
      end else begin
        chk($sformatf("result%0d", k), d, e);
      end
    end
    hold[k] = v && !out_ready;
    held[k] = d;
    if (in_valid && r) begin
      prod    = longint'($signed(in_data[15:8])) * longint'($signed(in_data[7:0]));
      part[k] = step(part[k], prod, cfg_outw(k), cfg_sat(k));
      if (in_last) begin
        q_push(k, part[k]);
        part[k] = 0;
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      q0.delete();
      q1.delete();
      q2.delete();
      for (int k = 0; k < 3; k++) begin
        part[k] = 0;
        hold[k] = 1'b0;
        held[k] = 0;
      end
    end else begin
      port_check(0, val_a, longint'($signed(data_a)), rdy_a);
      port_check(1, val_b, longint'($signed(data_b)), rdy_b);
      port_check(2, val_c, longint'($signed(data_c)), rdy_c);
    end
  end

  task automatic send(input int x, input int w, input bit last);
    int n;
    n        = 0;
    in_data  = {8'(x), 8'(w)};
    in_valid = 1'b1;
    in_last  = last;
    @(negedge clk);
    while (!rdy_a && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got no ready in %0d cycles, expected ready", n);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  bit rand_done;

  initial begin
    reset     = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    rand_done = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_valid", longint'(val_a), 0);
    chk("reset_data", longint'(data_a), 0);
    chk("reset_ready", longint'(rdy_a), 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(1);

    // Window arithmetic and two-cycle latency
    send(2, 3, 0);
    send(-4, 5, 0);
    send(7, -1, 1);
    @(negedge clk);
    chk("latency_not_early", longint'(val_a), 0);
    @(negedge clk);
    chk("latency_valid", longint'(val_a), 1);
    chk("window_sum_a", longint'(data_a), 24'hFFFFEB);
    chk("window_sum_c", longint'(data_c), 16'hFFEB);
    idle(2);

    // Back-to-back single-pair windows
    send(127, 127, 1);
    send(-128, -128, 1);
    @(negedge clk);
    chk("b2b_first_valid", longint'(val_a), 1);
    chk("b2b_first", longint'(data_a), 24'h003F01);
    @(negedge clk);
    chk("b2b_second_valid", longint'(val_a), 1);
    chk("b2b_second", longint'(data_a), 24'h004000);
    idle(2);

    // Backpressure: result 5 held, next pair waits
    out_ready = 1'b0;
    send(1, 5, 1);
    idle(1);
    in_data  = {8'(3), 8'(3)};
    in_valid = 1'b1;
    in_last  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_ready", longint'(rdy_a), 0);
      chk("stall_valid", longint'(val_a), 1);
      chk("stall_data", longint'(data_a), 5);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(3, 3, 1);
    @(negedge clk);
    chk("release_handoff", longint'(val_a), 0);
    @(negedge clk);
    chk("release_next", longint'(data_a), 9);
    idle(2);

    // Wrap versus saturation
    send(127, 127, 0);
    send(127, 127, 0);
    send(127, 127, 1);
    @(negedge clk);
    @(negedge clk);
    chk("wrap24", longint'(data_a), 24'h00BD03);
    chk("sat16", longint'(data_b), 16'h7FFF);
    chk("wrap16", longint'(data_c), 16'hBD03);
    idle(2);

    // Reset mid-window discards the partial sum and pairs offered during reset
    send(10, 10, 0);
    send(10, 10, 0);
    reset    = 1'b1;
    in_data  = {8'(50), 8'(50)};
    in_valid = 1'b1;
    in_last  = 1'b0;
    @(negedge clk);
    chk("ready_in_reset", longint'(rdy_a), 1);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    send(1, 1, 1);
    @(negedge clk);
    @(negedge clk);
    chk("after_reset", longint'(data_a), 1);
    idle(2);

    // Valid gaps inside a window
    send(3, 3, 0);
    idle(3);
    send(2, 2, 1);
    @(negedge clk);
    @(negedge clk);
    chk("gap_window", longint'(data_a), 13);
    idle(2);

    // Random windows, random valid gaps and random downstream ready
    fork
      begin
        for (int win = 0; win < 100; win++) begin
          int len;
          len = $urandom_range(1, 6);
          for (int j = 0; j < len; j++) begin
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
            send($urandom_range(0, 255), $urandom_range(0, 255), j == len - 1);
          end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    idle(10);
    chk("drain_a", longint'(q0.size()), 0);
    chk("drain_b", longint'(q1.size()), 0);
    chk("drain_c", longint'(q2.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
